// File: rtl/multiplier_controller_tainttrack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multiplier_ctrl_pkg
//  Description : Shared types and helpers for the taint-tracked shift-add
//                multiplier controller (state encoding, counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package multiplier_ctrl_pkg;

    // Controller state encoding; values are fixed so traces stay readable.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    // Bit-index counter width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage : multiplier_ctrl_pkg
`default_nettype wire

// File: rtl/multiplier_controller_tainttrack_if.sv
`default_nettype none
// ============================================================================
//  Module      : multiplier_controller_tainttrack_if
//  Description : Handshake and datapath-control bundle between the requester /
//                datapath side (master) and the multiplier controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface multiplier_controller_tainttrack_if #(
    parameter int WIDTH = 1024
);
    logic             start;
    logic             start_t;
    logic [WIDTH-1:0] multiplierReg;
    logic [WIDTH-1:0] multiplierReg_t;
    logic             mrld;
    logic             mdld;
    logic             rsclear;
    logic             rsload;
    logic             rsshr;
    logic             mrld_t;
    logic             mdld_t;
    logic             rsclear_t;
    logic             rsload_t;
    logic             rsshr_t;
    logic             busy;
    logic             done;
    logic             done_t;

    modport master (
        output start, start_t, multiplierReg, multiplierReg_t,
        input  mrld, mdld, rsclear, rsload, rsshr,
        input  mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t,
        input  busy, done, done_t
    );

    modport slave (
        input  start, start_t, multiplierReg, multiplierReg_t,
        output mrld, mdld, rsclear, rsload, rsshr,
        output mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t,
        output busy, done, done_t
    );
endinterface : multiplier_controller_tainttrack_if
`default_nettype wire

// File: rtl/multiplier_controller_tainttrack_bit_select.sv
`default_nettype none
// ============================================================================
//  Module      : mult_bit_select_tainttrack
//  Description : Picks the multiplier bit under test and its taint bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_bit_select_tainttrack #(
    parameter int WIDTH = 1024,
    parameter int CNT_W = 10
) (
    input  wire logic [WIDTH-1:0] i_vec,
    input  wire logic [WIDTH-1:0] i_vec_t,
    input  wire logic [CNT_W-1:0] i_idx,
    output logic                  o_bit,
    output logic                  o_bit_t
);
    // Plain index mux; the counter never exceeds WIDTH-1.
    always_comb begin
        o_bit   = i_vec[i_idx];
        o_bit_t = i_vec_t[i_idx];
    end
endmodule : mult_bit_select_tainttrack
`default_nettype wire

// File: rtl/multiplier_controller_tainttrack.sv
`default_nettype none
// ============================================================================
//  Module      : multiplier_controller_tainttrack
//  Description : Moore FSM sequencing the shift-add multiplier datapath, with
//                a sticky control-flow taint bit driving every strobe taint.
//  Revision    : 1.0 - initial release
// ============================================================================
module multiplier_controller_tainttrack
    import multiplier_ctrl_pkg::*;
#(
    parameter int WIDTH = 1024
) (
    input  wire logic clk,
    input  wire logic rst_n,
    multiplier_controller_tainttrack_if.slave bus
);
    localparam int               CNT_W      = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_taint;
    logic             w_taint_nxt;
    logic             w_bit;
    logic             w_bit_t;

    mult_bit_select_tainttrack #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_select (
        .i_vec   (bus.multiplierReg),
        .i_vec_t (bus.multiplierReg_t),
        .i_idx   (r_cnt),
        .o_bit   (w_bit),
        .o_bit_t (w_bit_t)
    );

    // State, bit counter and sticky taint register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_taint <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_taint <= w_taint_nxt;
        end
    end

    // Next-state, counter and taint decisions; a decision that consulted
    // tainted data taints everything from the next state onward.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_taint_nxt = r_taint;
        case (r_state)
            S_IDLE: begin
                // A tainted start could have flipped the decision either way.
                if (bus.start_t) w_taint_nxt = 1'b1;
                if (bus.start)   w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_TEST;
            end
            S_TEST: begin
                if (w_bit_t) w_taint_nxt = 1'b1;
                w_state_nxt = w_bit ? S_ADD : S_SHIFT;
            end
            S_ADD: begin
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + C_CNT_ONE;
                    w_state_nxt = S_TEST;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Moore output decode; strobe taints follow the taint bit regardless of
    // whether the strobe fires, since not strobing leaks just as much.
    always_comb begin
        bus.mrld      = 1'b0;
        bus.mdld      = 1'b0;
        bus.rsclear   = 1'b0;
        bus.rsload    = 1'b0;
        bus.rsshr     = 1'b0;
        bus.done      = 1'b0;
        bus.busy      = (r_state != S_IDLE);
        bus.mrld_t    = r_taint;
        bus.mdld_t    = r_taint;
        bus.rsclear_t = r_taint;
        bus.rsload_t  = r_taint;
        bus.rsshr_t   = r_taint;
        bus.done_t    = r_taint;
        case (r_state)
            S_LOAD: begin
                bus.mrld    = 1'b1;
                bus.mdld    = 1'b1;
                bus.rsclear = 1'b1;
            end
            S_ADD:   bus.rsload = 1'b1;
            S_SHIFT: bus.rsshr  = 1'b1;
            S_DONE:  bus.done   = 1'b1;
            default: ;
        endcase
    end

endmodule : multiplier_controller_tainttrack
`default_nettype wire

// File: tb/tb_multiplier_controller_tainttrack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiplier_controller_tainttrack
//  Description : Directed self-checking bench for the multiplier controller
//                at WIDTH=4 with hand-computed latencies and taint timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_controller_tainttrack;
    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    multiplier_controller_tainttrack_if #(.WIDTH(WIDTH)) bus ();

    multiplier_controller_tainttrack #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] taints();
        return {bus.mrld_t, bus.mdld_t, bus.rsclear_t, bus.rsload_t, bus.rsshr_t, bus.done_t};
    endfunction

    function automatic logic [5:0] strobes();
        return {bus.mrld, bus.mdld, bus.rsclear, bus.rsload, bus.rsshr, bus.done};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n               = 1'b0;
        bus.start           = 1'b0;
        bus.start_t         = 1'b0;
        bus.multiplierReg   = '0;
        bus.multiplierReg_t = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Starts one multiply at a negedge and observes it at every following
    // negedge until busy drops. exp_taint_at = first busy cycle with taint
    // (0 means the taint must stay low for the whole operation).
    task automatic run_op(input string tag, input logic [3:0] mr, input logic [3:0] mr_t,
                          input bit hold_start, input int exp_lat, input int exp_add,
                          input int exp_taint_at);
        int  busy_cnt;
        int  done_at;
        int  n_done;
        int  n_add;
        int  n_shr;
        int  n_ld;
        int  taint_at;
        int  incoherent;
        int  done_t_seen;
        bit  finished;
        busy_cnt = 0; done_at = 0; n_done = 0; n_add = 0; n_shr = 0; n_ld = 0;
        taint_at = 0; incoherent = 0; done_t_seen = 0; finished = 1'b0;
        @(negedge clk);
        bus.start           = 1'b1;
        bus.start_t         = 1'b0;
        bus.multiplierReg   = mr;
        bus.multiplierReg_t = mr_t;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!hold_start) bus.start = 1'b0;
            if (bus.busy) begin
                busy_cnt++;
                if (bus.mrld && bus.mdld && bus.rsclear) n_ld++;
                if (bus.rsload) n_add++;
                if (bus.rsshr)  n_shr++;
                if (bus.done) begin
                    n_done++;
                    done_at     = busy_cnt;
                    done_t_seen = int'(bus.done_t);
                end
                if (taints() != 6'b000000 && taints() != 6'b111111) incoherent++;
                if (taint_at == 0 && taints() != 6'b000000) taint_at = busy_cnt;
            end else if (busy_cnt > 0) begin
                finished = 1'b1;
                break;
            end
        end
        check({tag, "_finished"}, 32'(finished), 32'd1);
        check({tag, "_latency"},  busy_cnt, exp_lat);
        check({tag, "_done_at"},  done_at,  exp_lat);
        check({tag, "_done_cnt"}, n_done,   1);
        check({tag, "_load_cnt"}, n_ld,     1);
        check({tag, "_add_cnt"},  n_add,    exp_add);
        check({tag, "_shr_cnt"},  n_shr,    WIDTH);
        check({tag, "_taint_at"}, taint_at, exp_taint_at);
        check({tag, "_taint_coherent"}, incoherent, 0);
        check({tag, "_done_t"},   done_t_seen, (exp_taint_at != 0) ? 1 : 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n               = 1'b0;
        bus.start           = 1'b0;
        bus.start_t         = 1'b0;
        bus.multiplierReg   = '0;
        bus.multiplierReg_t = '0;
        repeat (2) @(negedge clk);
        check("reset_busy",    32'(bus.busy), 32'd0);
        check("reset_strobes", 32'(strobes()), 32'd0);
        check("reset_taints",  32'(taints()),  32'd0);
        rst_n = 1'b1;

        // Basic operand patterns, untainted.
        run_op("mr1011", 4'b1011, 4'b0000, 1'b0, 13, 3, 0);
        run_op("mr0000", 4'b0000, 4'b0000, 1'b0, 10, 0, 0);
        run_op("mr1111", 4'b1111, 4'b0000, 1'b0, 14, 4, 0);
        check("idle_untainted", 32'(taints()), 32'd0);

        // Tainted bit 1: cycles LOAD,TEST0,ADD,SHIFT,TEST1 clean, taint from 6.
        run_op("mr0101_t", 4'b0101, 4'b0010, 1'b0, 12, 2, 6);
        check("idle_taint_sticky", 32'(taints()), 32'h3f);
        repeat (3) @(negedge clk);
        check("idle_taint_sticky_later", 32'(taints()), 32'h3f);

        // Tainted start with start low: no operation, taint appears.
        do_reset();
        check("post_reset_taints", 32'(taints()), 32'd0);
        bus.start_t = 1'b1;
        @(negedge clk);
        bus.start_t = 1'b0;
        check("start_t_no_busy", 32'(bus.busy), 32'd0);
        check("start_t_taints",  32'(taints()), 32'h3f);
        repeat (4) @(negedge clk);
        check("start_t_still_idle", 32'(bus.busy), 32'd0);
        check("start_t_persist",    32'(taints()), 32'h3f);

        // start held high throughout: latency unchanged, restart after IDLE.
        do_reset();
        run_op("hold0110", 4'b0110, 4'b0000, 1'b1, 12, 2, 0);
        @(negedge clk);
        check("hold_restart_busy", 32'(bus.busy), 32'd1);
        check("hold_restart_load", 32'(bus.mrld), 32'd1);
        bus.start = 1'b0;

        // Async reset mid-ADD with taint already set by a tainted start.
        do_reset();
        @(negedge clk);
        bus.start           = 1'b1;
        bus.start_t         = 1'b1;
        bus.multiplierReg   = 4'b0001;
        bus.multiplierReg_t = 4'b0000;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.start_t = 1'b0;
        begin
            bit seen_add;
            seen_add = 1'b0;
            for (int c = 0; c < 10; c++) begin
                if (bus.rsload) begin
                    seen_add = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("midadd_reached", 32'(seen_add), 32'd1);
        end
        check("midadd_taint_before", 32'(taints()), 32'h3f);
        #2 rst_n = 1'b0;
        #1;
        check("midadd_rst_busy",   32'(bus.busy),   32'd0);
        check("midadd_rst_rsload", 32'(bus.rsload), 32'd0);
        check("midadd_rst_taints", 32'(taints()),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst0001", 4'b0001, 4'b0000, 1'b0, 11, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_multiplier_controller_tainttrack
`default_nettype wire
